uart_frame_packer: RTL
======================

// Module: uart_frame_packer
// PURPOSE
// - Parametrised successor to the fixed 8-to-24 byte packer between the UART receiver and the PT2262 encoder.
// - Collects NUM_BYTES received bytes, first byte into the MSBs, into one payload word.
// - Presents the word to the encoder with a valid/ready handshake.
// - Aborts partial frames after an inter-byte timeout and flags bytes that arrive while a word is still pending.
// PARAMETERS
// - NUM_BYTES       3    bytes per payload word (>=1); payload width W = 8*NUM_BYTES
// - TIMEOUT_CYCLES  300  idle clk cycles allowed between bytes of one frame; 0 = timeout disabled
// PORTS
// - clk        in   1    system clock; all logic on rising edge
// - reset      in   1    synchronous, active-high reset
// - in_valid   in   1    one-cycle strobe: in_data holds a received byte (UART rx valid)
// - in_data    in   8    received byte
// - out_ready  in   1    encoder idle and able to load (encoder done)
// - out_valid  out  1    out_data holds a complete word; level, held until accepted
// - out_data   out  W    payload word, byte 0 in bits [W-1:W-8]
// - busy       out  1    high while a frame is partially collected
// - frame_err  out  1    one-cycle pulse: frame aborted (timeout, or checksum mismatch)
// - overrun    out  1    one-cycle pulse: byte dropped because out_valid was high
// BEHAVIOUR
// - Reset: state IDLE; out_valid, busy, frame_err, overrun = 0; out_data = 0; byte count and timer = 0.
// - A reset asserted mid-frame or mid-hold discards all partial and pending data. No output is produced for that data.
// - States:
//   - IDLE: waiting for first byte.
//   - COLLECT: 1..NUM_BYTES-1 bytes held.
//   - HOLD: out_valid high.
// - IDLE + in_valid:
//   - Byte goes to shift register; count = 1.
//   - Go to COLLECT (busy = 1). If NUM_BYTES = 1, go to HOLD instead.
// - COLLECT + in_valid:
//   - Byte is shifted in; count++.
//   - On the final byte, out_data is loaded from the shift register and the state goes to HOLD.
// - Latency: out_valid rises on the clk edge after the edge that samples the final in_valid (1 cycle).
// - HOLD: out_valid stays 1 and out_data stays stable until a cycle where out_valid && out_ready.
//   - On that cycle the transfer completes and the state returns to IDLE. out_valid = 0 on the next cycle.
//   - out_data keeps its last value after the transfer.
// - HOLD + in_valid (including the transfer cycle): the byte is dropped and overrun pulses. No partial frame starts.
// - Timeout (TIMEOUT_CYCLES > 0):
//   - The timer loads TIMEOUT_CYCLES on every accepted byte in IDLE or COLLECT.
//   - The timer decrements on each COLLECT cycle without in_valid.
//   - When it reaches 0 in COLLECT: frame_err pulses, count clears, state returns to IDLE, busy = 0.
//   - in_valid in the same cycle the timer would expire: the byte is accepted and the timer reloads. No error.
// - Timer is inactive in IDLE and HOLD. If TIMEOUT_CYCLES = 0, the timer logic is not generated.
// - Widths:
//   - count: $clog2(NUM_BYTES+1) bits.
//   - timer: $clog2(TIMEOUT_CYCLES+1) bits.
//   - Counters never wrap; count never exceeds NUM_BYTES.
// CONFIGURATION
// - UART_FRAME_PACKER_CHECKSUM_EN defined:
//   - Each frame carries one extra trailing byte equal to the XOR of its NUM_BYTES payload bytes.
//   - COLLECT waits for NUM_BYTES+1 bytes; timeout also applies before the checksum byte.
//   - Checksum match: HOLD, with latency 1 cycle after the checksum byte.
//   - Checksum mismatch: frame discarded, frame_err pulses, state goes to IDLE, out_data unchanged.
// - Macro not defined: frames are exactly NUM_BYTES bytes, with no checksum logic; frame_err pulses on timeout only.
// TESTING
// - Run with NUM_BYTES = 3 and TIMEOUT_CYCLES = 300 unless stated otherwise.
// - Bytes AB,CD,EF 40 cycles apart, out_ready = 1
//   -> out_valid one cycle after EF, out_data = 0xABCDEF.
//   -> out_valid low the next cycle.
// - Full frame with out_ready = 0 for 500 cycles, then 1
//   -> out_valid and out_data = value held all 500 cycles.
//   -> Transfer on the first ready cycle.
//   -> A byte sent during the hold causes an overrun pulse and is not in the next frame.
// - Bytes 11,22, then 301 idle cycles, then 33,44,55
//   -> frame_err pulses once, 300 cycles after 22.
//   -> Next word = 0x334455.
// - Second byte exactly on the cycle the timer expires
//   -> No frame_err; the frame completes normally.
// - Reset asserted after 2 bytes, released, then bytes 01,02,03
//   -> All outputs 0 during reset.
//   -> Next word = 0x010203.
// - CHECKSUM_EN: bytes 12,34,56 with checksum 70 -> word 0x123456.
// - CHECKSUM_EN: bytes 12,34,56 with checksum 71 -> frame_err pulse, no out_valid.

Source files
------------

// File: rtl/uart_frame_packer.sv
// Packs NUM_BYTES received UART bytes (first byte in the MSBs) into one word and offers it with valid/ready.
// Defining UART_FRAME_PACKER_CHECKSUM_EN adds a trailing XOR checksum byte to every frame.
module uart_frame_packer #(
  parameter int NUM_BYTES      = 3,
  parameter int TIMEOUT_CYCLES = 300
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [8*NUM_BYTES-1:0] out_data,
  output logic                   busy,
  output logic                   frame_err,
  output logic                   overrun
);
  localparam int W  = 8 * NUM_BYTES;
  localparam int CW = $clog2(NUM_BYTES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          expire;
  logic          last_pos;
  logic          payload;
  logic          csum_ok;

`ifdef UART_FRAME_PACKER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  // With a checksum the frame ends on the byte after the last payload byte.
  assign last_pos = (count_q == CW'(NUM_BYTES));
  assign payload  = in_valid && ((state_q == IDLE) || ((state_q == COLLECT) && !last_pos));
  assign csum_ok  = (csum_q == in_data);

  always_comb begin
    csum_d = csum_q;
    if (payload) csum_d = (state_q == IDLE) ? in_data : (csum_q ^ in_data);
  end

  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`else
  assign last_pos = (count_q == CW'(NUM_BYTES - 1));
  assign payload  = in_valid && ((state_q == IDLE) || (state_q == COLLECT));
  assign csum_ok  = 1'b1;
`endif

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timer
      localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
      logic [TW-1:0] timer_q, timer_d;

      always_comb begin
        timer_d = '0;
        if (state_d == COLLECT) begin
          if (in_valid)             timer_d = TW'(TIMEOUT_CYCLES);
          else if (timer_q != '0)   timer_d = timer_q - TW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) timer_q <= '0;
        else       timer_q <= timer_d;
      end

      // A byte arriving on the expiry cycle wins over the timeout.
      assign expire = (state_q == COLLECT) && !in_valid && (timer_q == TW'(1));
    end else begin : g_no_timer
      assign expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = last_pos ? HOLD : COLLECT;
      COLLECT: begin
        if (in_valid && last_pos) state_d = csum_ok ? HOLD : IDLE;
        else if (expire)          state_d = IDLE;
      end
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == HOLD);
    busy      = (state_q == COLLECT);
    out_data  = out_data_q;
    frame_err = frame_err_q;
    overrun   = overrun_q;
  end

  // Bytes are written into their slot by position, so the finished word is shift_d itself.
  always_comb begin
    shift_d = shift_q;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (payload && (count_q == CW'(i))) shift_d[W-1-8*i -: 8] = in_data;
    end
    count_d = '0;
    if (state_d == COLLECT) count_d = payload ? (count_q + CW'(1)) : count_q;
    out_data_d = out_data_q;
    if ((state_d == HOLD) && (state_q != HOLD)) out_data_d = shift_d;
    frame_err_d = (state_q == COLLECT) && (expire || (in_valid && last_pos && !csum_ok));
    overrun_d   = (state_q == HOLD) && in_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end
endmodule
